fir_mem_loader: RTL and testbench
=================================

Name: fir_mem_loader

Overview:
- Write-side counterpart of the FIR coefficient/sample memory read path.
- Accepts one valid/ready word stream and writes H_MEMO_DEPTH coefficients into the h memory, then X_MEMO_DEPTH samples into the x memory.
- Signals completion so the address controller can start filtering.
- Sits between the host/testbench stream source and the h/x memory write ports.

Parameters:
- H_ADDR_WIDTH, 4, coefficient memory address width
- X_ADDR_WIDTH, 6, sample memory address width
- H_MEMO_DEPTH, 1<<H_ADDR_WIDTH, number of coefficients written per load
- X_MEMO_DEPTH, 1<<X_ADDR_WIDTH, number of samples written per load
- DATA_WIDTH, 32, word width (IEEE-754 single)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a load; honoured only in IDLE
- busy_i  in  1  filter running; stalls acceptance (s_ready forced low)
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream word
- s_last  in  1  marks final word of a load
- s_ready  out  1  loader can accept a word
- h_we  out  1  coefficient memory write strobe
- h_waddr  out  H_ADDR_WIDTH  coefficient write address
- h_wdata  out  DATA_WIDTH  coefficient write data
- x_we  out  1  sample memory write strobe
- x_waddr  out  X_ADDR_WIDTH  sample write address
- x_wdata  out  DATA_WIDTH  sample write data
- load_done_o  out  1  one-cycle pulse: load completed
- loaded_o  out  1  level: memories hold a complete load
- err_o  out  1  sticky: stream length mismatch

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; internal counters 0.
- Reset mid-load: returns to IDLE in the same cycle. Partially written memory contents are not restored, and loaded_o stays 0.
- States and transitions:
  - IDLE -> LOAD_H on start_i; start_i also clears loaded_o and err_o.
  - LOAD_H -> LOAD_X after accepting coefficient word H_MEMO_DEPTH-1.
  - LOAD_X -> DONE after accepting sample word X_MEMO_DEPTH-1.
  - DONE -> IDLE next cycle; load_done_o=1 and loaded_o set during DONE.
- start_i outside IDLE is ignored.
- s_ready = (state==LOAD_H or LOAD_X) and !busy_i. It is combinational from state/busy_i only and never depends on s_valid.
- Handshake: a word is accepted when s_valid && s_ready. s_valid without s_ready has no effect. s_data must be held stable by the source while stalled.
- Write latency: exactly 1 cycle.
  - The accepted word appears on h_wdata/x_wdata with its address on h_waddr/x_waddr, and the matching we high, in the cycle after acceptance.
  - h_we and x_we are never high together.
  - we deasserts when there is no acceptance.
- Addresses: an internal counter starts at 0 per region.
  - Coefficient i is written to h_waddr=i; sample j is written to x_waddr=j.
  - The counter width is sized so that depth-1 does not wrap early; the counter resets to 0 on region change.
- Completion timing: load_done_o pulses in the same cycle as the final x_we (i.e. the cycle after the last acceptance).
- s_last rules:
  - s_last on the final sample word is the correct termination.
  - s_last on any earlier word (LOAD_H, or LOAD_X before word X_MEMO_DEPTH-1): that word is still written; err_o=1; return to IDLE; no load_done_o; loaded_o stays 0.
  - Final sample word without s_last: load completes normally and err_o=1 (sticky until next start_i).
- busy_i rising mid-load: stalls acceptance with counters held; resumes when busy_i falls.
- busy_i is ignored in IDLE/DONE.

Optional Feature:
- Macro: FIR_LOADER_ZERO_PAD_EN.
- Defined: early s_last during LOAD_X is not an error. The block enters ZERO_FILL with s_ready=0 and writes 0 to the remaining sample addresses, one per cycle, with consecutive x_we. It then enters DONE; load_done_o pulses with the last zero write and err_o stays 0. ZERO_FILL ignores busy_i. Early s_last in LOAD_H remains an error.
- Not defined: no ZERO_FILL state; early s_last in LOAD_X follows the error rule above.

Test Plan:
- Reset, then start_i; stream 80 words (16 coeff 1..16, 64 samples 101..164) with s_valid continuous and s_last on word 80 -> h_we 16 consecutive cycles at addr 0..15 with data 1..16; then x_we at addr 0..63 with data 101..164; load_done_o single pulse with x_waddr=63; loaded_o=1; err_o=0.
- Same stream with s_valid toggling every other cycle and busy_i high for cycles 20-29 -> identical memory writes, no duplicates; s_ready=0 during busy_i.
- s_last asserted on word 40 -> word 40 written at x_waddr=23; err_o=1; state IDLE; loaded_o=0; no load_done_o. With FIR_LOADER_ZERO_PAD_EN: 40 zero writes at x_waddr 24..63, then load_done_o, err_o=0.
- Full 80-word load with s_last never asserted -> load_done_o pulses, loaded_o=1, err_o=1.
- rst_i asserted after 30 accepted words -> next cycle all outputs 0, s_ready=0; a new start_i restarts at h_waddr=0.
- start_i pulsed during LOAD_X -> ignored; addresses continue uninterrupted.

Source files
------------

// File: rtl/fir_mem_loader.sv
// rtl/fir_mem_loader.sv - stream loader writing FIR coefficients then samples into h/x memories.
// Optional macro FIR_LOADER_ZERO_PAD_EN: early s_last in the sample phase zero-fills the rest of x memory.
module fir_mem_loader #(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int H_MEMO_DEPTH = 1 << H_ADDR_WIDTH,
  parameter int X_MEMO_DEPTH = 1 << X_ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    busy_i,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    h_we,
  output logic [H_ADDR_WIDTH-1:0] h_waddr,
  output logic [DATA_WIDTH-1:0]   h_wdata,
  output logic                    x_we,
  output logic [X_ADDR_WIDTH-1:0] x_waddr,
  output logic [DATA_WIDTH-1:0]   x_wdata,
  output logic                    load_done_o,
  output logic                    loaded_o,
  output logic                    err_o
);

  // One spare bit so a terminal count of depth-1 can never alias to zero.
  localparam int CNT_W = ((H_ADDR_WIDTH > X_ADDR_WIDTH) ? H_ADDR_WIDTH : X_ADDR_WIDTH) + 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_MEMO_DEPTH - 1);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_MEMO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_H    = 3'd1,
    LOAD_X    = 3'd2,
`ifdef FIR_LOADER_ZERO_PAD_EN
    ZERO_FILL = 3'd3,
`endif
    DONE      = 3'd4
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   err_d, loaded_d;
  logic                   h_we_d, x_we_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic                   accept;

  assign s_ready     = ((state == LOAD_H) || (state == LOAD_X)) && !busy_i;
  assign accept      = s_valid && s_ready;
  assign load_done_o = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    err_d    = err_o;
    loaded_d = loaded_o;
    h_we_d   = 1'b0;
    x_we_d   = 1'b0;
    wdata_d  = s_data;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD_H;
          cnt_d    = '0;
          err_d    = 1'b0;
          loaded_d = 1'b0;
        end
      end
      LOAD_H: begin
        if (accept) begin
          h_we_d = 1'b1;
          if (s_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt == H_LAST) begin
            state_d = LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (accept) begin
          x_we_d = 1'b1;
          if (cnt == X_LAST) begin
            state_d  = DONE;
            loaded_d = 1'b1;
            err_d    = err_o | !s_last;
            cnt_d    = '0;
          end else if (s_last) begin
`ifdef FIR_LOADER_ZERO_PAD_EN
            state_d = ZERO_FILL;
            cnt_d   = cnt + 1'b1;
`else
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
`ifdef FIR_LOADER_ZERO_PAD_EN
      ZERO_FILL: begin
        x_we_d  = 1'b1;
        wdata_d = '0;
        if (cnt == X_LAST) begin
          state_d  = DONE;
          loaded_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Write port registers give the fixed one-cycle write latency.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt      <= '0;
      err_o    <= 1'b0;
      loaded_o <= 1'b0;
      h_we     <= 1'b0;
      h_waddr  <= '0;
      h_wdata  <= '0;
      x_we     <= 1'b0;
      x_waddr  <= '0;
      x_wdata  <= '0;
    end else begin
      cnt      <= cnt_d;
      err_o    <= err_d;
      loaded_o <= loaded_d;
      h_we     <= h_we_d;
      x_we     <= x_we_d;
      if (h_we_d) begin
        h_waddr <= cnt[H_ADDR_WIDTH-1:0];
        h_wdata <= wdata_d;
      end
      if (x_we_d) begin
        x_waddr <= cnt[X_ADDR_WIDTH-1:0];
        x_wdata <= wdata_d;
      end
    end
  end

endmodule

// File: tb/tb_fir_mem_loader.sv
// tb/tb_fir_mem_loader.sv - scoreboard bench for fir_mem_loader (default or FIR_LOADER_ZERO_PAD_EN build).
module tb_fir_mem_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        h_we;
  logic [3:0]  h_waddr;
  logic [31:0] h_wdata;
  logic        x_we;
  logic [5:0]  x_waddr;
  logic [31:0] x_wdata;
  logic        load_done_o;
  logic        loaded_o;
  logic        err_o;

  fir_mem_loader dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .busy_i(busy_i),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .h_we(h_we), .h_waddr(h_waddr), .h_wdata(h_wdata),
    .x_we(x_we), .x_waddr(x_waddr), .x_wdata(x_wdata),
    .load_done_o(load_done_o), .loaded_o(loaded_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_h;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  done_cnt = 0;
  logic [31:0] done_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (h_we === 1'b1 && x_we === 1'b1) check("we_overlap", 1, 0);
    if (h_we === 1'b1 || x_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_side", {31'd0, h_we}, {31'd0, e.is_h});
        check("waddr", h_we ? {28'd0, h_waddr} : {26'd0, x_waddr}, e.addr);
        check("wdata", h_we ? h_wdata : x_wdata, e.data);
      end
    end
    if (load_done_o === 1'b1) begin
      done_cnt++;
      done_addr = {26'd0, x_waddr};
      check("done_with_xwe", {31'd0, x_we}, 1);
    end
  end

  // Drives one load; acceptance is predicted from the bench's own view of the phase.
  task automatic run_load(input int last_idx, input bit toggle, input int busy_lo,
                          input int busy_hi, input int abort_at, input int start_at);
    int k = 0;
    int cyc = 0;
    bit loading;
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    check("start_clears_err", {31'd0, err_o}, 0);
    check("start_clears_loaded", {31'd0, loaded_o}, 0);
    loading = 1'b1;
    while (loading && cyc < 400) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = (k < 16) ? k + 1 : 85 + k;
      s_last  = (k == last_idx);
      busy_i  = (cyc >= busy_lo) && (cyc <= busy_hi);
      start_i = (k == start_at);
      @(negedge clk);
      check("s_ready", {31'd0, s_ready}, {31'd0, !busy_i});
      @(posedge clk);
      if (s_valid && !busy_i) begin
        wr_t w;
        w.is_h = (k < 16);
        w.addr = (k < 16) ? k : k - 16;
        w.data = s_data;
        exp_q.push_back(w);
        if (k == last_idx && k < 79) begin
          loading = 1'b0;
`ifdef FIR_LOADER_ZERO_PAD_EN
          if (k >= 16) begin
            for (int j = k - 15; j < 64; j++) begin
              w.is_h = 1'b0;
              w.addr = j;
              w.data = 0;
              exp_q.push_back(w);
            end
          end
`endif
        end
        k++;
        if (k == 80 || k == abort_at) loading = 1'b0;
      end
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    busy_i  = 1'b0;
    start_i = 1'b0;
    if (cyc >= 400) check("load_timeout", 1, 0);
  endtask

  task automatic finish_checks(input int exp_done, input int exp_loaded, input int exp_err);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    if (exp_done == 1) check("done_xaddr", done_addr, 63);
    check("loaded", {31'd0, loaded_o}, exp_loaded);
    check("err", {31'd0, err_o}, exp_err);
    check("idle_ready", {31'd0, s_ready}, 0);
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", {31'd0, s_ready}, 0);
    check("rst_h_we", {31'd0, h_we}, 0);
    check("rst_h_waddr", {28'd0, h_waddr}, 0);
    check("rst_h_wdata", h_wdata, 0);
    check("rst_x_we", {31'd0, x_we}, 0);
    check("rst_x_waddr", {26'd0, x_waddr}, 0);
    check("rst_x_wdata", x_wdata, 0);
    check("rst_load_done", {31'd0, load_done_o}, 0);
    check("rst_loaded", {31'd0, loaded_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1; rst_i = 1'b0;

    run_load(79, 1'b0, -1, -1, -1, -1);
    finish_checks(1, 1, 0);

    run_load(79, 1'b1, 20, 29, -1, -1);
    finish_checks(1, 1, 0);

    run_load(39, 1'b0, -1, -1, -1, -1);
`ifdef FIR_LOADER_ZERO_PAD_EN
    finish_checks(1, 1, 0);
`else
    finish_checks(0, 0, 1);
`endif

    run_load(-1, 1'b0, -1, -1, -1, -1);
    finish_checks(1, 1, 1);

    run_load(79, 1'b0, -1, -1, 30, -1);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    check("abort_queue", exp_q.size(), 0);
    @(posedge clk); #1; rst_i = 1'b0;

    run_load(79, 1'b0, -1, -1, -1, 50);
    finish_checks(1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
